// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, READ, WRITE, RESP), also
//                 exported on the arbiter's dbg_state port.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_interface: single-transaction memory port.
//   read_address / read_address_valid : read request (requester -> responder)
//   read_data / read_data_valid       : read completion (responder -> requester)
//   write_address / write_data / write_valid : write request
//   write_ack                          : write completion
//
// Handshake: a requester raises *_valid with a stable payload and holds
// both until the responder pulses the matching completion
// (read_data_valid or write_ack) for one cycle. The request is retired
// on the clock edge where valid and completion are both high; the
// requester may drop valid or change the payload only after that edge.
interface mem_interface #(
  parameter int MEMADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [MEMADDR_WIDTH-1:0] read_address;
  logic                     read_address_valid;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_data_valid;
  logic [MEMADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     write_valid;
  logic                     write_ack;

  modport requester (
    output read_address, read_address_valid,
    output write_address, write_data, write_valid,
    input  read_data, read_data_valid, write_ack
  );

  modport responder (
    input  read_address, read_address_valid,
    input  write_address, write_data, write_valid,
    output read_data, read_data_valid, write_ack
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index of the last winner
//   found : at least one request is set
//   idx   : first set request scanning ptr+1, ptr+2, ... modulo NUM_REQ
module mem_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Offset NUM_REQ wraps back to ptr itself, so a lone requester that
  // just won can win again.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        idx   = wrap(int'(ptr) + k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between
// NUM_REQ requesters, one transaction in flight at a time.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_read_address/_valid  : per-requester read requests (slice i)
//   req_read_data            : last captured read data, broadcast
//   req_read_data_valid      : one-cycle read completion to the winner
//   req_write_address/_data/_valid : per-requester write requests
//   req_write_ack            : one-cycle write completion to the winner
//   grant                    : one-hot owner, 0 while IDLE
//   dbg_state                : current FSM state
//   mem                      : downstream memory port (requester side)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MEMADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ*MEMADDR_WIDTH-1:0] req_read_address,
  input  logic [NUM_REQ-1:0]               req_read_address_valid,
  output logic [DATA_WIDTH-1:0]            req_read_data,
  output logic [NUM_REQ-1:0]               req_read_data_valid,
  input  logic [NUM_REQ*MEMADDR_WIDTH-1:0] req_write_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_write_data,
  input  logic [NUM_REQ-1:0]               req_write_valid,
  output logic [NUM_REQ-1:0]               req_write_ack,
  output logic [NUM_REQ-1:0]               grant,
  output arb_state_t                       dbg_state,
  mem_interface.requester                  mem
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Unpacked views of the flat per-requester buses.
  logic [MEMADDR_WIDTH-1:0] w_rd_addr [NUM_REQ];
  logic [MEMADDR_WIDTH-1:0] w_wr_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_wr_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_rd_addr[g] = req_read_address[g*MEMADDR_WIDTH +: MEMADDR_WIDTH];
    assign w_wr_addr[g] = req_write_address[g*MEMADDR_WIDTH +: MEMADDR_WIDTH];
    assign w_wr_data[g] = req_write_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  arb_state_t               r_state;
  logic [IDX_W-1:0]         r_ptr;
  logic [NUM_REQ-1:0]       r_grant;
  logic [MEMADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_mem_rav;
  logic                     r_mem_wv;
  logic [NUM_REQ-1:0]       r_req_rdv;
  logic [NUM_REQ-1:0]       r_req_wack;

  logic [NUM_REQ-1:0]       w_req;
  logic                     w_found;
  logic [IDX_W-1:0]         w_idx;
  logic [NUM_REQ-1:0]       w_win_onehot;

  assign w_req        = req_read_address_valid | req_write_valid;
  assign w_win_onehot = NUM_REQ'(1) << w_idx;

  mem_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_grant    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mem_rav  <= 1'b0;
      r_mem_wv   <= 1'b0;
      r_req_rdv  <= '0;
      r_req_wack <= '0;
    end else begin
      // Completion pulses last exactly one cycle (the RESP cycle).
      r_req_rdv  <= '0;
      r_req_wack <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ptr   <= w_idx;
            r_grant <= w_win_onehot;
            // Read wins over write when one requester asserts both.
            if (req_read_address_valid[w_idx]) begin
              r_addr    <= w_rd_addr[w_idx];
              r_mem_rav <= 1'b1;
              r_state   <= READ;
            end else begin
              r_addr   <= w_wr_addr[w_idx];
              r_wdata  <= w_wr_data[w_idx];
              r_mem_wv <= 1'b1;
              r_state  <= WRITE;
            end
          end
        end
        READ: begin
          // A stray write_ack here is deliberately ignored.
          if (mem.read_data_valid) begin
            r_rdata   <= mem.read_data;
            r_mem_rav <= 1'b0;
            r_req_rdv <= r_grant;
            r_state   <= RESP;
          end
        end
        WRITE: begin
          if (mem.write_ack) begin
            r_mem_wv   <= 1'b0;
            r_req_wack <= r_grant;
            r_state    <= RESP;
          end
        end
        RESP: begin
          // Requests are not sampled here; the requester updates them
          // during the following IDLE cycle.
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.read_address       = r_addr;
  assign mem.read_address_valid = r_mem_rav;
  assign mem.write_address      = r_addr;
  assign mem.write_data         = r_wdata;
  assign mem.write_valid        = r_mem_wv;

  assign req_read_data       = r_rdata;
  assign req_read_data_valid = r_req_rdv;
  assign req_write_ack       = r_req_wack;
  assign grant               = r_grant;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed testbench for mem_arbiter (NUM_REQ = 4).
// The memory responder is either driven by hand (man_*) or, with
// auto_resp set, answers combinationally in the first cycle of valid
// with read data = ~read_address.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N*AW-1:0] req_read_address;
  logic [N-1:0]    req_read_address_valid;
  logic [DW-1:0]   req_read_data;
  logic [N-1:0]    req_read_data_valid;
  logic [N*AW-1:0] req_write_address;
  logic [N*DW-1:0] req_write_data;
  logic [N-1:0]    req_write_valid;
  logic [N-1:0]    req_write_ack;
  logic [N-1:0]    grant;
  arb_state_t      dbg_state;

  mem_interface #(.MEMADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

  logic          auto_resp;
  logic          man_rdv;
  logic          man_wack;
  logic [DW-1:0] man_rdata;

  assign mif.read_data_valid = auto_resp ? mif.read_address_valid : man_rdv;
  assign mif.read_data       = auto_resp ? ~mif.read_address : man_rdata;
  assign mif.write_ack       = auto_resp ? mif.write_valid : man_wack;

  mem_arbiter #(.NUM_REQ(N), .MEMADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_read_address       (req_read_address),
    .req_read_address_valid (req_read_address_valid),
    .req_read_data          (req_read_data),
    .req_read_data_valid    (req_read_data_valid),
    .req_write_address      (req_write_address),
    .req_write_data         (req_write_data),
    .req_write_valid        (req_write_valid),
    .req_write_ack          (req_write_ack),
    .grant                  (grant),
    .dbg_state              (dbg_state),
    .mem                    (mif.requester)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int r, input logic v, input logic [AW-1:0] a);
    req_read_address_valid[r]     = v;
    req_read_address[r*AW +: AW]  = a;
  endtask

  task automatic set_wr(input int r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write_valid[r]            = v;
    req_write_address[r*AW +: AW] = a;
    req_write_data[r*DW +: DW]    = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [AW-1:0] cur_addr [2];
  logic [AW-1:0] next_addr;
  logic [DW-1:0] exp_d;
  int            rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_read_address       = '0;
    req_read_address_valid = '0;
    req_write_address      = '0;
    req_write_data         = '0;
    req_write_valid        = '0;
    auto_resp = 1'b0;
    man_rdv   = 1'b0;
    man_wack  = 1'b0;
    man_rdata = '0;

    // ---- reset state ----
    rst = 1'b1;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_rav", mif.read_address_valid, 0);
    check("rst_wv", mif.write_valid, 0);
    check("rst_raddr", mif.read_address, 0);
    check("rst_rdv", req_read_data_valid, 0);
    check("rst_wack", req_write_ack, 0);
    check("rst_rdata", req_read_data, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // ---- single read: requester 2, 0x100, response at k=3 ----
    set_rd(2, 1'b1, 32'h100);                       // cycle 0
    tick();                                         // cycle 1
    check("rd1_rav_c1", mif.read_address_valid, 1);
    check("rd1_addr", mif.read_address, 32'h100);
    check("rd1_grant", grant, 4'b0100);
    check("rd1_state", dbg_state, READ);
    tick();                                         // cycle 2
    check("rd1_rav_c2", mif.read_address_valid, 1);
    tick();                                         // cycle 3
    check("rd1_rav_c3", mif.read_address_valid, 1);
    check("rd1_rdv_c3", req_read_data_valid, 0);
    man_rdv   = 1'b1;
    man_rdata = 32'hDEADBEEF;
    tick();                                         // cycle 4
    check("rd1_rdv_c4", req_read_data_valid, 4'b0100);
    check("rd1_rdata", req_read_data, 32'hDEADBEEF);
    check("rd1_rav_c4", mif.read_address_valid, 0);
    check("rd1_state_resp", dbg_state, RESP);
    man_rdv = 1'b0;
    set_rd(2, 1'b0, '0);
    tick();                                         // cycle 5
    check("rd1_rdv_c5", req_read_data_valid, 0);
    check("rd1_grant_c5", grant, 0);
    check("rd1_state_idle", dbg_state, IDLE);
    check("rd1_rdata_hold", req_read_data, 32'hDEADBEEF);

    // ---- round-robin: all four hold writes ----
    do_reset();
    auto_resp = 1'b1;
    for (int i = 0; i < N; i++) set_wr(i, 1'b1, 32'h1000 + 32'(i * 16), 32'hC0DE0000 + 32'(i));
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rr_grant", grant, 64'(1 << rr_order[t]));
      check("rr_wv", mif.write_valid, 1);
      check("rr_waddr", mif.write_address, 32'h1000 + 32'(rr_order[t] * 16));
      check("rr_wdata", mif.write_data, 32'hC0DE0000 + 32'(rr_order[t]));
      check("rr_wack_pre", req_write_ack, 0);
      tick();
      check("rr_wack", req_write_ack, 64'(1 << rr_order[t]));
      tick();
      check("rr_wack_post", req_write_ack, 0);
      check("rr_state_idle", dbg_state, IDLE);
      if (t == 4) req_write_valid = '0;
    end

    // ---- read/write precedence on requester 1 ----
    set_rd(1, 1'b1, 32'h2000);
    set_wr(1, 1'b1, 32'h2100, 32'h55AA55AA);
    tick();
    check("prec_state_rd", dbg_state, READ);
    check("prec_grant_rd", grant, 4'b0010);
    check("prec_rav", mif.read_address_valid, 1);
    check("prec_wv_rd", mif.write_valid, 0);
    tick();
    check("prec_rdv", req_read_data_valid, 4'b0010);
    check("prec_wack_rd", req_write_ack, 0);
    check("prec_rdata", req_read_data, 32'hFFFFDFFF);
    tick();
    check("prec_idle", dbg_state, IDLE);
    set_rd(1, 1'b0, '0);
    tick();
    check("prec_state_wr", dbg_state, WRITE);
    check("prec_grant_wr", grant, 4'b0010);
    check("prec_wv", mif.write_valid, 1);
    check("prec_waddr", mif.write_address, 32'h2100);
    check("prec_wdata", mif.write_data, 32'h55AA55AA);
    tick();
    check("prec_wack", req_write_ack, 4'b0010);
    check("prec_rdv_wr", req_read_data_valid, 0);
    tick();
    set_wr(1, 1'b0, '0, '0);
    auto_resp = 1'b0;

    // ---- stray responses ----
    set_rd(3, 1'b1, 32'h300);
    tick();
    check("stray_state_rd", dbg_state, READ);
    man_wack = 1'b1;
    tick();
    check("stray_state_hold", dbg_state, READ);
    check("stray_rav_hold", mif.read_address_valid, 1);
    check("stray_wack_out", req_write_ack, 0);
    check("stray_grant", grant, 4'b1000);
    man_wack  = 1'b0;
    man_rdv   = 1'b1;
    man_rdata = 32'h12345678;
    tick();
    check("stray_state_resp", dbg_state, RESP);
    check("stray_rdv", req_read_data_valid, 4'b1000);
    check("stray_rdata", req_read_data, 32'h12345678);
    man_rdv = 1'b0;
    set_rd(3, 1'b0, '0);
    tick();
    check("stray_idle", dbg_state, IDLE);
    man_rdv   = 1'b1;
    man_rdata = 32'hBAD0BAD0;
    man_wack  = 1'b1;
    tick();
    check("stray_idle_state", dbg_state, IDLE);
    check("stray_idle_rdata", req_read_data, 32'h12345678);
    check("stray_idle_rdv", req_read_data_valid, 0);
    check("stray_idle_wack", req_write_ack, 0);
    check("stray_idle_grant", grant, 0);
    man_rdv  = 1'b0;
    man_wack = 1'b0;

    // ---- reset in the middle of a write ----
    set_wr(2, 1'b1, 32'h3000, 32'h00000077);
    tick();
    check("rstw_state", dbg_state, WRITE);
    check("rstw_wv_pre", mif.write_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstw_wv_async", mif.write_valid, 0);
    check("rstw_grant_async", grant, 0);
    check("rstw_state_async", dbg_state, IDLE);
    check("rstw_waddr_async", mif.write_address, 0);
    set_wr(0, 1'b1, 32'h3300, 32'h00000011);
    set_wr(3, 1'b1, 32'h3330, 32'h00000033);
    tick();
    rst = 1'b0;
    check("rstw_no_ack", req_write_ack, 0);
    tick();
    check("rstw_next_grant", grant, 4'b0001);
    check("rstw_next_addr", mif.write_address, 32'h3300);
    man_wack = 1'b1;
    tick();
    check("rstw_next_ack", req_write_ack, 4'b0001);
    man_wack = 1'b0;
    req_write_valid = '0;
    tick();
    check("rstw_idle", dbg_state, IDLE);

    // ---- zero-wait responder: 8 back-to-back reads, requesters 1,0,1,0,... ----
    auto_resp   = 1'b1;
    cur_addr[0] = 32'h4000;
    cur_addr[1] = 32'h4004;
    next_addr   = 32'h4008;
    set_rd(0, 1'b1, cur_addr[0]);
    set_rd(1, 1'b1, cur_addr[1]);
    for (int t = 0; t < 8; t++) begin
      int r;
      r = (t % 2 == 0) ? 1 : 0;
      tick();
      check("zw_state", dbg_state, READ);
      check("zw_grant", grant, 64'(1 << r));
      check("zw_addr", mif.read_address, cur_addr[r]);
      tick();
      exp_d = ~cur_addr[r];
      check("zw_rdv", req_read_data_valid, 64'(1 << r));
      check("zw_rdata", req_read_data, exp_d);
      tick();
      check("zw_idle", dbg_state, IDLE);
      if (t >= 6) begin
        set_rd(r, 1'b0, '0);
      end else begin
        cur_addr[r] = next_addr;
        next_addr   = next_addr + 32'd4;
        set_rd(r, 1'b1, cur_addr[r]);
      end
    end
    tick();
    check("zw_final_idle", dbg_state, IDLE);
    check("zw_final_grant", grant, 0);

    // ---- report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
